// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu instruction side.
// Provides the instruction and program-counter widths, the instruction class
// constants, the issuer state encoding and the per-class hold-cycle helper.
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int PC_BITS     = 5;
  localparam int STORE_DEPTH = 2 ** PC_BITS;
  localparam int STD_CYCLES  = 3;
  localparam int MEM_CYCLES  = 4;
  // Wide enough to hold the largest hold count (MEM_CYCLES).
  localparam int CNT_BITS    = 3;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_HALT  = 2'b00;
  localparam cls_t CLS_STD   = 2'b01;
  localparam cls_t CLS_LOAD  = 2'b10;
  localparam cls_t CLS_STORE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    ISSUE = 2'b10
  } state_e;

  // Class field sits in the two most significant bits of the word.
  function automatic cls_t instr_class(input logic [INSTR_WIDTH-1:0] word);
    return word[INSTR_WIDTH-1 -: 2];
  endfunction

  // Number of cycles the CU spends on one instruction of the given class.
  function automatic logic [CNT_BITS-1:0] hold_cycles(input cls_t cls);
    logic [CNT_BITS-1:0] res;
    case (cls)
      CLS_STD:             res = CNT_BITS'(STD_CYCLES);
      CLS_LOAD, CLS_STORE: res = CNT_BITS'(MEM_CYCLES);
      default:             res = {CNT_BITS{1'b0}};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// Bus bundle between the instruction issuer and its controller.
// master: drives the program-store write port and start, observes the issue
//         outputs (instr, pc, busy, done, issued).
// slave : the issuer itself.
interface instr_issuer_if;
  import cpu_pkg::*;

  logic                   prog_we;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;
  logic [PC_BITS:0]       issued;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  instr, pc, busy, done, issued
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output instr, pc, busy, done, issued
  );

endinterface

// File: rtl/instr_issuer_prog_store.sv
// Program store for the instruction issuer.
// Synchronous write, combinational read; contents are not reset.
// Ports: clk, we_i/waddr_i/wdata_i (write port), raddr_i/rdata_o (read port).
module prog_store
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [PC_BITS-1:0]     waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i,
  input  logic [PC_BITS-1:0]     raddr_i,
  output logic [INSTR_WIDTH-1:0] rdata_o
);

  logic [INSTR_WIDTH-1:0] mem_q [STORE_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read returns the pre-edge contents, so a same-cycle write is not
  // visible to a fetch made in that cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: after start, presents the stored program word by word on
// instr, holding each word for the cycles its class needs in the CU, and stops
// on a halt word or after the last store address.
// Ports: clk, rst (async, active-low), bus (instr_issuer_if.slave):
//   prog_we/prog_addr/prog_data load the store (IDLE only), start begins a run,
//   instr/pc show the word being executed, busy covers PRIME+ISSUE, done pulses
//   once at run end, issued counts completed instructions of the run.
module instr_issuer
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_issuer_if.slave bus
);

  localparam logic [PC_BITS-1:0] PC_LAST = {PC_BITS{1'b1}};

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PC_BITS:0]       issued_q, issued_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  logic [PC_BITS-1:0]     rd_addr_s;
  logic [INSTR_WIDTH-1:0] rd_data_s;
  logic                   rd_halt_s;
  logic                   at_last_s;
  logic                   store_we_s;
  logic                   run_end_s;

  assign store_we_s = bus.prog_we && (state_q == IDLE);

  prog_store u_store (
    .clk     (clk),
    .we_i    (store_we_s),
    .waddr_i (bus.prog_addr),
    .wdata_i (bus.prog_data),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Fetch address: word 0 when starting, otherwise the word after pc.
  always_comb begin
    if (state_q == IDLE) begin
      rd_addr_s = {PC_BITS{1'b0}};
    end else begin
      rd_addr_s = pc_q + PC_BITS'(1);
    end
  end

  assign rd_halt_s = (instr_class(rd_data_s) == CLS_HALT);
  assign at_last_s = (pc_q == PC_LAST);
  // At the last address the fetch wraps to 0, so the end test must not rely
  // on rd_halt_s alone.
  assign run_end_s = at_last_s || rd_halt_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      instr_q  <= {INSTR_WIDTH{1'b0}};
      pc_q     <= {PC_BITS{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= {(PC_BITS+1){1'b0}};
      cnt_q    <= {CNT_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !rd_halt_s) begin
          state_d = PRIME;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: state_d = ISSUE;
      ISSUE: begin
        if ((cnt_q == {CNT_BITS{1'b0}}) && run_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        instr_d = {INSTR_WIDTH{1'b0}};
        busy_d  = 1'b0;
        if (bus.start) begin
          issued_d = {(PC_BITS+1){1'b0}};
          if (rd_halt_s) begin
            // Empty program: report completion without ever going busy.
            done_d = 1'b1;
          end else begin
            instr_d = rd_data_s;
            pc_d    = {PC_BITS{1'b0}};
            busy_d  = 1'b1;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      PRIME: begin
        // PRIME already covers the CU's first step, hence the minus one.
        busy_d = 1'b1;
        cnt_d  = hold_cycles(instr_class(instr_q)) - CNT_BITS'(1);
      end
      ISSUE: begin
        if (cnt_q != {CNT_BITS{1'b0}}) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else begin
          issued_d = issued_q + (PC_BITS+1)'(1);
          if (run_end_s) begin
            instr_d = {INSTR_WIDTH{1'b0}};
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = {CNT_BITS{1'b0}};
          end else begin
            // Back-to-back issue: the next word replaces this one with no gap.
            instr_d = rd_data_s;
            pc_d    = pc_q + PC_BITS'(1);
            cnt_d   = hold_cycles(instr_class(rd_data_s)) - CNT_BITS'(1);
          end
        end
      end
      default: begin
        instr_d = {INSTR_WIDTH{1'b0}};
        busy_d  = 1'b0;
        cnt_d   = {CNT_BITS{1'b0}};
      end
    endcase
  end

  assign bus.instr  = instr_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.issued = issued_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: a constant table of small programs,
// a trace-level reference model for directed and random runs, and hand-written
// sequences for start/write during a run and reset in mid-run.
module tb_instr_issuer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_issuer_if bus ();

  instr_issuer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic [5:0]  issued;
  } rec_t;

  typedef struct {
    logic [19:0] w0, w1, w2, w3;
    int          exp_busy;
    int          exp_issued;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [19:0] mdl_mem [32];
  logic [4:0]  mdl_pc     = 5'd0;
  logic [5:0]  mdl_issued = 6'd0;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic rec_t sample();
    rec_t r;
    r = {bus.instr, bus.pc, bus.busy, bus.done, bus.issued};
    return r;
  endfunction

  task automatic load(input logic [4:0] addr, input logic [19:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    @(negedge clk);
    bus.prog_we   = 1'b0;
    mdl_mem[addr] = data;
  endtask

  // Builds the expected per-cycle trace from the program contents, then runs
  // it. s1/s2: cycles at which start is re-asserted during the run.
  // we_at: cycle of an ignored store write during the run; -2 writes in the
  // start cycle itself (the write lands, the run uses the old word 0).
  task automatic run_check(input string nm, input int s1, input int s2, input int we_at,
                           input logic [4:0] we_addr, input logic [19:0] we_data);
    rec_t exp_q [$];
    rec_t r;
    int   n;
    int   h;
    int   len;
    n = 0;
    while (n < 32 && mdl_mem[n][19:18] != 2'b00) n++;
    if (n == 0) begin
      r = {20'h0, mdl_pc, 1'b0, 1'b1, 6'd0};
      exp_q.push_back(r);
      mdl_issued = 6'd0;
    end else begin
      for (int k = 0; k < n; k++) begin
        h = (mdl_mem[k][19:18] == 2'b01) ? 3 : 4;
        if (k == 0) h = h + 1;
        for (int j = 0; j < h; j++) begin
          r = {mdl_mem[k], 5'(k), 1'b1, 1'b0, 6'(k)};
          exp_q.push_back(r);
        end
      end
      r = {20'h0, 5'(n - 1), 1'b0, 1'b1, 6'(n)};
      exp_q.push_back(r);
      mdl_pc     = 5'(n - 1);
      mdl_issued = 6'(n);
    end
    len = exp_q.size();
    @(negedge clk);
    bus.start = 1'b1;
    if (we_at == -2) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = we_addr;
      bus.prog_data = we_data;
      mdl_mem[we_addr] = we_data;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.start     = ((i == s1) || (i == s2)) && (i <= len - 2);
      bus.prog_we   = (i == we_at) && (i <= len - 2);
      bus.prog_addr = we_addr;
      bus.prog_data = we_data;
      chk(nm, 64'(sample()), 64'(exp_q[i]));
    end
    @(negedge clk);
    r = {20'h0, mdl_pc, 1'b0, 1'b0, mdl_issued};
    chk({nm, "_idle"}, 64'(sample()), 64'(r));
  endtask

  initial begin
    int busy_cnt;
    int dones;
    int len_r;

    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 5'd0;
    bus.prog_data = 20'h0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = 20'h0;

    tbl[0] = '{20'h41000, 20'h00000, 20'h00000, 20'h00000, 4, 1};
    tbl[1] = '{20'h41000, 20'h80010, 20'h00000, 20'h00000, 8, 2};
    tbl[2] = '{20'hC0001, 20'h41000, 20'h80000, 20'h00000, 12, 3};
    tbl[3] = '{20'h00000, 20'h41000, 20'h80000, 20'h00000, 0, 0};
    tbl[4] = '{20'h40000, 20'h40001, 20'h40002, 20'h00000, 10, 3};
    tbl[5] = '{20'h80000, 20'h00000, 20'hC0000, 20'h00000, 5, 1};

    // Reset state
    #1;
    chk("reset", 64'(sample()), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_release", 64'(sample()), 64'(0));

    // Table of small programs: busy length, issued count, single done pulse
    for (int t = 0; t < 6; t++) begin
      load(5'd0, tbl[t].w0);
      load(5'd1, tbl[t].w1);
      load(5'd2, tbl[t].w2);
      load(5'd3, tbl[t].w3);
      @(negedge clk);
      bus.start = 1'b1;
      busy_cnt = 0;
      dones    = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          dones++;
          break;
        end
      end
      chk("tbl_busy", 64'(busy_cnt), 64'(tbl[t].exp_busy));
      chk("tbl_issued", 64'(bus.issued), 64'(tbl[t].exp_issued));
      chk("tbl_done", 64'(dones), 64'(1));
    end

    // Single std word, then std+load
    load(5'd0, 20'h41000);
    load(5'd1, 20'h00000);
    run_check("one_std", -1, -1, -1, 5'd0, 20'h0);
    load(5'd1, 20'h80010);
    load(5'd2, 20'h00000);
    run_check("std_load", -1, -1, -1, 5'd0, 20'h0);

    // start re-asserted and store write while busy: both ignored
    run_check("busy_ignore", 2, 5, 3, 5'd1, 20'h4ABCD);
    run_check("store_intact", -1, -1, -1, 5'd0, 20'h0);

    // start with a same-cycle write to word 0: old word runs, new word next
    run_check("start_we_same", -1, -1, -2, 5'd0, 20'h80001);
    run_check("after_we", -1, -1, -1, 5'd0, 20'h0);

    // Reset in mid-run: asynchronous clear, no done, program intact
    load(5'd0, 20'h41000);
    load(5'd1, 20'h80010);
    load(5'd2, 20'h00000);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_async", 64'(sample()), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_done", 64'(sample()), 64'(0));
    mdl_pc     = 5'd0;
    mdl_issued = 6'd0;
    run_check("rerun_after_rst", -1, -1, -1, 5'd0, 20'h0);

    // Full store of store-class words: ends at pc 31 with no wrap
    for (int i = 0; i < 32; i++) load(5'(i), 20'hC0000 | 20'(i));
    run_check("full_store", -1, -1, -1, 5'd0, 20'h0);
    chk("full_pc", 64'(bus.pc), 64'(31));
    chk("full_issued", 64'(bus.issued), 64'(32));

    // Random programs with random ignored start/write during the run
    for (int r = 0; r < 20; r++) begin
      len_r = $urandom_range(1, 10);
      for (int k = 0; k < len_r; k++) begin
        load(5'(k), {2'($urandom_range(1, 3)), 18'($urandom)});
      end
      load(5'(len_r), 20'h00000);
      run_check("random", $urandom_range(0, 30), -1, $urandom_range(0, 30),
                5'($urandom), 20'($urandom));
    end

    // Halt at word 0: done pulse only, pc and busy untouched
    load(5'd0, 20'h00000);
    run_check("halt_first", -1, -1, -1, 5'd0, 20'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
